regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file at the write-back end of the pipeline.
- Consumes the write-back triple produced by the MEM/WB pipeline register: destination address, write enable and write data.
- Serves two operand reads to the decode stage in the same cycle.
- 32 x 32-bit storage; register $0 is hardwired to zero; optional same-cycle write-to-read bypass.

Parameters:
- REG_NUM, 32, number of architectural registers.
- REG_ADDR_W, 5, register address width (log2 REG_NUM).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high (asserted level `RstEnable); sampled only at posedge clk.
- we  input  1  write enable from the write-back stage (`WriteEnable active).
- waddr  input  REG_ADDR_W  write destination register.
- wdata  input  DATA_W  write data.
- re1  input  1  read enable, port 1 (`ReadEnable active).
- raddr1  input  REG_ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1.
- re2  input  1  read enable, port 2.
- raddr2  input  REG_ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2.

Behaviour:
- Storage: array regs[0..REG_NUM-1] of DATA_W bits.
- Reset:
  - On posedge clk with rst asserted, every entry is cleared to `ZeroWord.
  - Any write presented in the same cycle is dropped.
  - Clearing takes a single cycle; there is no multi-cycle clear sequence.
- Write:
  - On posedge clk with rst deasserted, we asserted and waddr != 0: regs[waddr] <= wdata.
  - waddr == 0 is ignored; regs[0] stays 0 permanently.
  - Write latency: visible in the array one cycle after the edge.
- Read: combinational, evaluated independently per port, in priority order:
  1. rst asserted -> `ZeroWord. This is the reset value of rdata1/rdata2.
  2. raddr == 0 -> `ZeroWord, regardless of any write to address 0.
  3. Bypass hit (feature enabled only): re, we, raddr == waddr -> wdata.
  4. re asserted -> regs[raddr].
  5. re deasserted -> `ZeroWord.
- Both ports may read the same address in the same cycle; each returns identical data.
- A write and two reads all in the same cycle are legal. There is no structural hazard and no stall output.
- Reset mid-operation: rst overrides any in-flight write. Outputs read zero while rst is held and on the first read after release.
- Address width: waddr/raddr are exactly REG_ADDR_W bits; out-of-range addresses are impossible when REG_NUM = 2^REG_ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: read priority item 3 is active. A read of the register being written this cycle returns the new wdata combinationally, giving 0-cycle write-to-read visibility and removing the WB->ID data hazard.
- Undefined: item 3 is removed. A same-cycle read returns the old array value, and the new value is visible from the next cycle. The pipeline must then stall or forward the hazard elsewhere.

Decomposition:
- Shared defines header holds: `RegAddrBus, `RegBus, `RegNum, `RegNumLog2, `NOPRegAddr, `ZeroWord, `WriteEnable, `ReadEnable, `RstEnable.
- One sub-module: regfile_rd_port.
  - Implements the combinational read priority mux (rst / zero-register / bypass / array / disabled).
  - Instantiated twice, once per read port.
  - The bypass term lives inside it under REGFILE_BYPASS_EN.

Test Plan:
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5; assert rst for one edge; deassert; read r5 on port 1.
  - Response: rdata1 == 0 during rst and after release.
- Zero register:
  - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF; next cycle read raddr1=0, raddr2=0.
  - Response: rdata1 == rdata2 == 0.
- Normal write/read:
  - Stimulus: write r3=0x12345678; next cycle re1=1, raddr1=3, re2=0.
  - Response: rdata1 == 0x12345678, rdata2 == 0.
- Same-cycle hazard:
  - Stimulus: r7 holds 0x11; in one cycle write r7=0x22 and read raddr1=7.
  - Response: with REGFILE_BYPASS_EN, rdata1 == 0x22. Without it, rdata1 == 0x11 that cycle and 0x22 the next.
- Dual port plus write collision:
  - Stimulus: r1=0xA, r2=0xB; same cycle read raddr1=1, raddr2=2 while writing r2=0xC.
  - Response: rdata1 == 0xA; rdata2 == 0xC (bypass) or 0xB (no bypass).
- Reset beats write:
  - Stimulus: rst=1 and we=1, waddr=9, wdata=0x55 on the same edge; release; read r9.
  - Response: rdata == 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the write-back register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// The legacy backtick defines (`RegBus, `ZeroWord, ...) are kept here so
// older files that use them still compile. New code uses the localparams below.
`ifndef REGFILE_DEFINES_SVH
`define REGFILE_DEFINES_SVH
`define RegAddrBus  4:0
`define RegBus      31:0
`define RegNum      32
`define RegNumLog2  5
`define NOPRegAddr  5'b00000
`define ZeroWord    32'h0000_0000
`define WriteEnable 1'b1
`define ReadEnable  1'b1
`define RstEnable   1'b1
`endif

package regfile_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [DATA_W-1:0]     ZERO_WORD    = '0;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;
    localparam logic RST_ENABLE   = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset, zero register, optional bypass, array, disabled.
// Latency: 0 cycles (pure combinational mux).
// Backpressure: none; the result is valid in the same cycle as the address.
//
// Ports: rst, re, raddr, arr_dat (the array entry at raddr, selected by the top),
// then, only with REGFILE_BYPASS_EN defined, we/waddr/wdata for the bypass.
// Output: rdata.
import regfile_pkg::*;

module regfile_rd_port #(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DAT_W  = DATA_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DAT_W-1:0]  arr_dat,
`ifdef REGFILE_BYPASS_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DAT_W-1:0]  wdata,
`endif
    output logic [DAT_W-1:0]  rdata
);

    always_comb begin
        rdata = '0;
        if (rst == RST_ENABLE) begin
            rdata = '0;
        end else if (raddr == '0) begin
            // r0 reads zero even while a write to address 0 is presented.
            rdata = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (re == READ_ENABLE && we == WRITE_ENABLE && raddr == waddr) begin
            // The value being written this cycle is forwarded straight to decode.
            rdata = wdata;
`endif
        end else if (re == READ_ENABLE) begin
            rdata = arr_dat;
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32x32 general-purpose register file: one write-back port, two decode read ports, r0 = 0.
// Latency: writes are visible in the array one cycle after the edge; reads are combinational.
// Backpressure: none; a write and two reads in the same cycle are always accepted.
//
// Ports: clk, rst (sync, active-high); we/waddr/wdata write port;
//        re1/raddr1/rdata1 and re2/raddr2/rdata2 read ports.
// Option: define REGFILE_BYPASS_EN to forward same-cycle write data to the readers.
import regfile_pkg::*;

module regfile #(
    parameter int REG_NUM    = regfile_pkg::REG_NUM,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
    parameter int DATA_W     = regfile_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re1,
    input  logic [REG_ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic                  re2,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] regs [REG_NUM];

    // Reset clears every entry in one cycle and drops any write presented with it.
    // Entry 0 is cleared but never written, so it stays zero permanently.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we == WRITE_ENABLE && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    regfile_rd_port #(
        .ADDR_W (REG_ADDR_W),
        .DAT_W  (DATA_W)
    ) u_rd_port1 (
        .rst     (rst),
        .re      (re1),
        .raddr   (raddr1),
        .arr_dat (regs[raddr1]),
`ifdef REGFILE_BYPASS_EN
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
`endif
        .rdata   (rdata1)
    );

    regfile_rd_port #(
        .ADDR_W (REG_ADDR_W),
        .DAT_W  (DATA_W)
    ) u_rd_port2 (
        .rst     (rst),
        .re      (re2),
        .raddr   (raddr2),
        .arr_dat (regs[raddr2]),
`ifdef REGFILE_BYPASS_EN
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
`endif
        .rdata   (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset clear, r0, write/read, same-cycle hazard, collisions.
// Latency: inputs change 1ns after posedge; combinational outputs are checked 1ns later.
// Backpressure: n/a.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int tests_run = 0;
    int tests_failed = 0;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        #2;
        check("reset_state_rd1", rdata1, 32'h0);
        check("reset_state_rd2", rdata2, 32'h0);
        tick();
        rst = 1'b0;

        // Reset clear
        write_reg(5'd5, 32'hDEAD_BEEF);
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        check("r5_written", rdata1, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check("r5_during_rst", rdata1, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("r5_after_rst", rdata1, 32'h0);

        // Zero register: write to r0 is ignored, also during the write cycle
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        check("r0_same_cycle", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_rd1", rdata1, 32'h0);
        check("r0_rd2", rdata2, 32'h0);

        // Normal write/read, port 2 disabled
        write_reg(5'd3, 32'h1234_5678);
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b0; raddr2 = 5'd3;
        #1;
        check("r3_rd1", rdata1, 32'h1234_5678);
        check("r3_rd2_disabled", rdata2, 32'h0);

        // Same-cycle hazard on r7
        write_reg(5'd7, 32'h11);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22;
        re1 = 1'b1; raddr1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_same_cycle", rdata1, 32'h22);
`else
        check("hazard_same_cycle", rdata1, 32'h11);
`endif
        tick();
        we = 1'b0;
        #1;
        check("hazard_next_cycle", rdata1, 32'h22);

        // Disabled read port never bypasses
        we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
        re1 = 1'b0; raddr1 = 5'd4;
        #1;
        check("bypass_re_off", rdata1, 32'h0);
        tick();
        we = 1'b0;

        // Dual port plus write collision
        write_reg(5'd1, 32'hA);
        write_reg(5'd2, 32'hB);
        we = 1'b1; waddr = 5'd2; wdata = 32'hC;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        #1;
        check("collide_rd1", rdata1, 32'hA);
`ifdef REGFILE_BYPASS_EN
        check("collide_rd2", rdata2, 32'hC);
`else
        check("collide_rd2", rdata2, 32'hB);
`endif
        tick();
        we = 1'b0;
        #1;
        check("collide_rd2_next", rdata2, 32'hC);
        raddr1 = 5'd2;
        #1;
        check("same_addr_both_ports", rdata1, 32'hC);

        // Reset beats write on the same edge
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        re1 = 1'b1; raddr1 = 5'd9;
        #1;
        check("rst_write_same_cycle", rdata1, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        check("r9_after_rst", rdata1, 32'h0);
        check("r3_cleared", rdata2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
